// File: rtl/keystream_pkg.sv
// Shared types and constants for the keystream arbiter slice.
package keystream_pkg;

    localparam int HASH_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DELIVER
    } arb_state_t;

endpackage

// File: rtl/keystream_rr_pick.sv
// Round-robin pick: first requester at or after the pointer (wrapping) whose mask bit is set.
module keystream_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_found
);

    localparam logic [PTR_W:0] NREQ = (PTR_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0] w_rot;
    logic [PTR_W:0]     w_off;
    logic [PTR_W:0]     w_sum;

    // Rotating the doubled mask puts the pointer position at bit 0.
    always_comb begin
        w_rot   = NUM_REQ'({i_mask, i_mask} >> i_ptr);
        o_found = 1'b0;
        w_off   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_found && w_rot[k]) begin
                o_found = 1'b1;
                w_off   = (PTR_W + 1)'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= NREQ) begin
            w_sum = w_sum - NREQ;
        end
        o_idx = w_sum[PTR_W-1:0];
    end

endmodule

// File: rtl/keystream_arbiter.sv
// Shares one hash-byte generator between NUM_REQ consumers: round-robin grant,
// per-requester pending counters, generator watchdog and sticky error flags.
module keystream_arbiter
    import keystream_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int PEND_DEPTH     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_pulse,
    output logic [HASH_BYTE_W-1:0] byte_out,
    output logic [NUM_REQ-1:0]     byte_valid,
    output logic                   gen_request_pulse,
    input  logic [HASH_BYTE_W-1:0] gen_byte_in,
    input  logic                   gen_byte_pulse_in,
    input  logic                   clear_err,
    output logic                   timeout_err,
    output logic                   overflow_err,
    output logic                   busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(PEND_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(PEND_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [CNT_W-1:0]       r_pend [NUM_REQ];
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_grant;
    logic [HASH_BYTE_W-1:0] r_byte;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_timeout_err;
    logic                   r_overflow_err;

    logic [NUM_REQ-1:0]     w_pend_nz;
    logic [NUM_REQ-1:0]     w_release;
    logic [NUM_REQ-1:0]     w_ovf;
    logic [PTR_W-1:0]       w_pick_idx;
    logic                   w_pick_found;
    logic                   w_tmo_expire;
    logic [PTR_W-1:0]       w_next_ptr;

    keystream_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_mask  (w_pend_nz),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_comb begin
        w_pend_nz = '0;
        w_ovf     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pend_nz[i] = (r_pend[i] != '0);
            w_ovf[i]     = req_pulse[i] && !w_release[i] && (r_pend[i] == PEND_MAX);
        end
        w_next_ptr = (r_grant == LAST_REQ) ? '0 : r_grant + 1'b1;
    end

    // A generator pulse in the expiry cycle takes priority over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_tmo_expire = 1'b0;
        w_release    = '0;
        case (r_state)
            IDLE:    if (w_pick_found) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT: begin
                if (gen_byte_pulse_in) begin
                    w_next_state = DELIVER;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo_expire = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DELIVER: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (w_tmo_expire || (r_state == DELIVER)) begin
            w_release = NUM_REQ'(1) << r_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_grant        <= '0;
            r_byte         <= '0;
            r_tmo          <= '0;
            r_timeout_err  <= 1'b0;
            r_overflow_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_pulse[i] && !w_release[i] && (r_pend[i] != PEND_MAX)) begin
                    r_pend[i] <= r_pend[i] + 1'b1;
                end else if (!req_pulse[i] && w_release[i]) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
            end
            case (r_state)
                IDLE:  if (w_pick_found) r_grant <= w_pick_idx;
                ISSUE: r_tmo <= '0;
                WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (gen_byte_pulse_in) r_byte <= gen_byte_in;
                end
                default: ;
            endcase
            if (w_release != '0) begin
                r_rr_ptr <= w_next_ptr;
            end
            if (w_tmo_expire) begin
                r_timeout_err <= 1'b1;
            end else if (clear_err) begin
                r_timeout_err <= 1'b0;
            end
            if (|w_ovf) begin
                r_overflow_err <= 1'b1;
            end else if (clear_err) begin
                r_overflow_err <= 1'b0;
            end
        end
    end

    assign byte_out          = r_byte;
    assign byte_valid        = (r_state == DELIVER) ? (NUM_REQ'(1) << r_grant) : '0;
    assign gen_request_pulse = (r_state == ISSUE);
    assign busy              = (r_state != IDLE);
    assign timeout_err       = r_timeout_err;
    assign overflow_err      = r_overflow_err;

endmodule

// File: tb/tb_keystream_arbiter.sv
// Directed bench for keystream_arbiter with a small generator model and a delivery log.
module tb_keystream_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_pulse;
    logic [7:0] byte_out;
    logic [1:0] byte_valid;
    logic       gen_request_pulse;
    logic [7:0] gen_byte_in;
    logic       gen_byte_pulse_in;
    logic       clear_err;
    logic       timeout_err;
    logic       overflow_err;
    logic       busy;

    int vectors;
    int miscompares;

    // generator model controls (written by the main thread only)
    logic [7:0] gen_bytes [32];
    int         gen_wr;
    int         gen_delay;
    logic       gen_hold;
    logic       gen_mute;
    int         spur_req;
    // generator model state (written by the generator process only)
    int         gen_rd;
    int         spur_done;
    // monitor log (written by the monitor only)
    logic [1:0] dlog_v [64];
    logic [7:0] dlog_b [64];
    int         dcount;
    int         greq;

    keystream_arbiter #(
        .NUM_REQ        (2),
        .PEND_DEPTH     (3),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_pulse         (req_pulse),
        .byte_out          (byte_out),
        .byte_valid        (byte_valid),
        .gen_request_pulse (gen_request_pulse),
        .gen_byte_in       (gen_byte_in),
        .gen_byte_pulse_in (gen_byte_pulse_in),
        .clear_err         (clear_err),
        .timeout_err       (timeout_err),
        .overflow_err      (overflow_err),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Generator: answers a request gen_delay cycles later, optionally held or muted.
    initial begin
        gen_byte_in       = 8'h00;
        gen_byte_pulse_in = 1'b0;
        gen_rd            = 0;
        spur_done         = 0;
        forever begin
            @(posedge clk);
            #1;
            gen_byte_pulse_in = 1'b0;
            if (spur_req != spur_done) begin
                gen_byte_in       = 8'hEE;
                gen_byte_pulse_in = 1'b1;
                spur_done         = spur_req;
            end else if (gen_request_pulse && !gen_mute && (gen_rd != gen_wr)) begin
                gen_byte_in = gen_bytes[gen_rd];
                gen_rd      = gen_rd + 1;
                for (int k = 0; k < gen_delay; k++) begin
                    @(posedge clk);
                    #1;
                end
                while (gen_hold) begin
                    @(posedge clk);
                    #1;
                end
                gen_byte_pulse_in = 1'b1;
            end
        end
    end

    initial begin
        dcount = 0;
        greq   = 0;
        forever begin
            @(negedge clk);
            if (gen_request_pulse) greq = greq + 1;
            if (byte_valid != 2'b00) begin
                if (dcount < 64) begin
                    dlog_v[dcount] = byte_valid;
                    dlog_b[dcount] = byte_out;
                end
                dcount = dcount + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_byte(input logic [7:0] b);
        gen_bytes[gen_wr] = b;
        gen_wr = gen_wr + 1;
    endtask

    task automatic wait_deliv(input int target, input int budget, output bit ok);
        ok = (dcount >= target);
        for (int k = 0; k < budget && !ok; k++) begin
            step();
            ok = (dcount >= target);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++; if (byte_out !== 8'h00) begin miscompares++; $display("FAIL reset_byte_out: got %h want 00", byte_out); end
        vectors++; if (byte_valid !== 2'b00) begin miscompares++; $display("FAIL reset_byte_valid: got %b want 00", byte_valid); end
        vectors++; if (gen_request_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_gen_req: got %b want 0", gen_request_pulse); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL reset_overflow_err: got %b want 0", overflow_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int base_d;
        int base_g;
        base_d = dcount;
        base_g = greq;
        gen_delay = 3;
        push_byte(8'hA5);
        req_pulse = 2'b01;          // cycle 0
        step();
        req_pulse = 2'b00;          // cycle 1
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_c1_busy: got %b want 0", busy); end
        step();                     // cycle 2: ISSUE
        vectors++; if (gen_request_pulse !== 1'b1) begin miscompares++; $display("FAIL single_c2_gen_req: got %b want 1", gen_request_pulse); end
        step();                     // cycle 3: WAIT
        vectors++; if (gen_request_pulse !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_c3_wait: got req=%b busy=%b want req=0 busy=1", gen_request_pulse, busy); end
        step();
        step();                     // cycle 5: generator pulse
        vectors++; if (byte_valid !== 2'b00) begin miscompares++; $display("FAIL single_c5_valid: got %b want 00", byte_valid); end
        step();                     // cycle 6: DELIVER
        vectors++; if (byte_valid !== 2'b01 || byte_out !== 8'hA5) begin miscompares++; $display("FAIL single_c6_deliver: got valid=%b byte=%h want valid=01 byte=a5", byte_valid, byte_out); end
        step();                     // cycle 7
        vectors++; if (byte_valid !== 2'b00 || busy !== 1'b0 || byte_out !== 8'hA5) begin miscompares++; $display("FAIL single_c7_after: got valid=%b busy=%b byte=%h want 00 0 a5", byte_valid, busy, byte_out); end
        repeat (5) step();
        vectors++; if (dcount - base_d !== 1 || greq - base_g !== 1) begin miscompares++; $display("FAIL single_counts: got deliv=%0d req=%0d want 1 1", dcount - base_d, greq - base_g); end
    endtask

    task automatic test_contention();
        int  base_d;
        bit  ok;
        do_reset();                 // rr_ptr back to 0
        base_d = dcount;
        gen_delay = 3;
        push_byte(8'h11);
        push_byte(8'h22);
        req_pulse = 2'b11;
        step();
        req_pulse = 2'b00;
        wait_deliv(base_d + 2, 60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL contention_deliv: got %0d want %0d deliveries", dcount - base_d, 2); end
        vectors++; if (dlog_v[base_d] !== 2'b01 || dlog_b[base_d] !== 8'h11) begin miscompares++; $display("FAIL contention_first: got %b/%h want 01/11", dlog_v[base_d], dlog_b[base_d]); end
        vectors++; if (dlog_v[base_d+1] !== 2'b10 || dlog_b[base_d+1] !== 8'h22) begin miscompares++; $display("FAIL contention_second: got %b/%h want 10/22", dlog_v[base_d+1], dlog_b[base_d+1]); end
        // a second round must again start at requester 0
        push_byte(8'h33);
        push_byte(8'h44);
        step();
        req_pulse = 2'b11;
        step();
        req_pulse = 2'b00;
        wait_deliv(base_d + 4, 60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL contention_round2_deliv: got %0d want %0d deliveries", dcount - base_d, 4); end
        vectors++; if (dlog_v[base_d+2] !== 2'b01 || dlog_b[base_d+2] !== 8'h33) begin miscompares++; $display("FAIL contention_rrptr: got %b/%h want 01/33", dlog_v[base_d+2], dlog_b[base_d+2]); end
        vectors++; if (dlog_v[base_d+3] !== 2'b10 || dlog_b[base_d+3] !== 8'h44) begin miscompares++; $display("FAIL contention_round2_second: got %b/%h want 10/44", dlog_v[base_d+3], dlog_b[base_d+3]); end
        repeat (3) step();
    endtask

    task automatic test_saturation();
        int base_d;
        int base_g;
        bit ok;
        base_d = dcount;
        base_g = greq;
        gen_delay = 3;
        gen_hold  = 1'b1;
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        for (int k = 0; k < 4; k++) begin
            req_pulse = 2'b10;
            step();
        end
        req_pulse = 2'b00;
        vectors++; if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL sat_overflow_err: got %b want 1", overflow_err); end
        repeat (6) step();
        gen_hold = 1'b0;
        wait_deliv(base_d + 3, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sat_deliv: got %0d want %0d deliveries", dcount - base_d, 3); end
        repeat (20) step();
        vectors++; if (dcount - base_d !== 3 || greq - base_g !== 3) begin miscompares++; $display("FAIL sat_counts: got deliv=%0d req=%0d want 3 3", dcount - base_d, greq - base_g); end
        vectors++; if (dlog_v[base_d] !== 2'b10 || dlog_v[base_d+1] !== 2'b10 || dlog_v[base_d+2] !== 2'b10 || dlog_b[base_d+2] !== 8'h33) begin miscompares++; $display("FAIL sat_owner: got %b %b %b last=%h want 10 10 10 33", dlog_v[base_d], dlog_v[base_d+1], dlog_v[base_d+2], dlog_b[base_d+2]); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL sat_no_timeout: got %b want 0", timeout_err); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL sat_clear: got %b want 0", overflow_err); end
    endtask

    task automatic test_timeout();
        int base_d;
        int base_g;
        bit ok;
        base_d = dcount;
        base_g = greq;
        gen_mute  = 1'b1;
        gen_delay = 3;
        req_pulse = 2'b01;          // cycles 0 and 1: two requests from requester 0
        step();
        step();
        req_pulse = 2'b00;          // cycle 2: ISSUE
        vectors++; if (gen_request_pulse !== 1'b1) begin miscompares++; $display("FAIL tmo_issue: got %b want 1", gen_request_pulse); end
        repeat (64) step();         // cycle 66: last WAIT cycle
        vectors++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL tmo_before: got err=%b busy=%b want 0 1", timeout_err, busy); end
        step();                     // cycle 67: back in IDLE
        vectors++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL tmo_expired: got err=%b busy=%b want 1 0", timeout_err, busy); end
        gen_mute = 1'b0;
        push_byte(8'h5A);
        step();                     // cycle 68: remaining request reissued
        vectors++; if (gen_request_pulse !== 1'b1) begin miscompares++; $display("FAIL tmo_reissue: got %b want 1", gen_request_pulse); end
        wait_deliv(base_d + 1, 20, ok);
        vectors++; if (!ok || dlog_v[base_d] !== 2'b01 || dlog_b[base_d] !== 8'h5A) begin miscompares++; $display("FAIL tmo_deliver: got ok=%b %b/%h want 1 01/5a", ok, dlog_v[base_d], dlog_b[base_d]); end
        repeat (8) step();
        vectors++; if (busy !== 1'b0 || greq - base_g !== 2 || dcount - base_d !== 1) begin miscompares++; $display("FAIL tmo_pending: got busy=%b req=%0d deliv=%0d want 0 2 1", busy, greq - base_g, dcount - base_d); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_boundaries();
        int base_d;
        bit ok;
        bit bad;
        base_d = dcount;
        bad = 1'b0;
        spur_req = spur_req + 1;    // generator pulse while IDLE
        repeat (5) begin
            step();
            if (byte_valid !== 2'b00 || busy !== 1'b0) bad = 1'b1;
        end
        vectors++; if (bad || dcount != base_d) begin miscompares++; $display("FAIL idle_pulse_ignored: got deliv=%0d flag=%b want 0 0", dcount - base_d, bad); end
        vectors++; if (byte_out !== 8'h5A) begin miscompares++; $display("FAIL idle_byte_hold: got %h want 5a", byte_out); end
        gen_delay = 3;
        push_byte(8'h61);
        push_byte(8'h62);
        req_pulse = 2'b01;          // cycle 0
        step();
        req_pulse = 2'b00;
        repeat (5) step();          // cycle 6: DELIVER
        vectors++; if (byte_valid !== 2'b01 || byte_out !== 8'h61) begin miscompares++; $display("FAIL own_deliver: got %b/%h want 01/61", byte_valid, byte_out); end
        req_pulse = 2'b01;          // new request during own DELIVER
        step();
        req_pulse = 2'b00;
        wait_deliv(base_d + 2, 30, ok);
        vectors++; if (!ok || dlog_v[base_d+1] !== 2'b01 || dlog_b[base_d+1] !== 8'h62) begin miscompares++; $display("FAIL own_second: got ok=%b %b/%h want 1 01/62", ok, dlog_v[base_d+1], dlog_b[base_d+1]); end
        repeat (10) step();
        vectors++; if (dcount - base_d !== 2 || busy !== 1'b0 || overflow_err !== 1'b0) begin miscompares++; $display("FAIL own_net_zero: got deliv=%0d busy=%b ovf=%b want 2 0 0", dcount - base_d, busy, overflow_err); end
    endtask

    task automatic test_reset_mid_wait();
        int base_d;
        int base_g;
        bit bad;
        base_d = dcount;
        base_g = greq;
        bad = 1'b0;
        gen_delay = 3;
        gen_hold  = 1'b1;
        push_byte(8'h77);
        req_pulse = 2'b01;          // cycle 0
        step();
        req_pulse = 2'b00;
        repeat (3) step();          // cycle 4: WAIT
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstwait_busy: got %b want 1", busy); end
        do_reset();
        vectors++; if (busy !== 1'b0 || byte_valid !== 2'b00 || gen_request_pulse !== 1'b0 || byte_out !== 8'h00 || timeout_err !== 1'b0 || overflow_err !== 1'b0) begin miscompares++; $display("FAIL rstwait_outputs: got busy=%b valid=%b req=%b byte=%h terr=%b oerr=%b want all 0", busy, byte_valid, gen_request_pulse, byte_out, timeout_err, overflow_err); end
        gen_hold = 1'b0;            // late generator pulse
        repeat (8) begin
            step();
            if (byte_valid !== 2'b00 || busy !== 1'b0) bad = 1'b1;
        end
        vectors++; if (bad || dcount != base_d || greq - base_g !== 1 || byte_out !== 8'h00) begin miscompares++; $display("FAIL rstwait_late_pulse: got flag=%b deliv=%0d req=%0d byte=%h want 0 0 1 00", bad, dcount - base_d, greq - base_g, byte_out); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_pulse   = 2'b00;
        clear_err   = 1'b0;
        gen_wr      = 0;
        gen_delay   = 3;
        gen_hold    = 1'b0;
        gen_mute    = 1'b0;
        spur_req    = 0;
        test_reset();
        test_single();
        test_contention();
        test_saturation();
        test_timeout();
        test_boundaries();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
